// File: rtl/sad_array_if.sv
// Row-streaming handshake and result bus between a pixel source and the SAD array.
interface sad_array_if;
  logic        start;
  logic        row_valid;
  logic        row_ready;
  logic [31:0] cur_row;
  logic [55:0] ref_row;
  logic        busy;
  logic        done;
  logic [11:0] sum0, sum1, sum2, sum3, sum4, sum5, sum6, sum7;
  logic [11:0] sum8, sum9, sum10, sum11, sum12, sum13, sum14, sum15;

  modport master (
    output start, row_valid, cur_row, ref_row,
    input  row_ready, busy, done,
    input  sum0, sum1, sum2, sum3, sum4, sum5, sum6, sum7,
    input  sum8, sum9, sum10, sum11, sum12, sum13, sum14, sum15
  );

  modport slave (
    input  start, row_valid, cur_row, ref_row,
    output row_ready, busy, done,
    output sum0, sum1, sum2, sum3, sum4, sum5, sum6, sum7,
    output sum8, sum9, sum10, sum11, sum12, sum13, sum14, sum15
  );
endinterface

// File: rtl/sad_array.sv
// 4x4 block SAD over a 7x7 search window: 16 candidates accumulated one reference row per cycle.
module sad_array (
  input  logic         clk,
  input  logic         rst_n,
  sad_array_if.slave   bus
);
  localparam int DATA_W = 8;
  localparam int SUM_W  = 12;

  typedef enum logic [1:0] {IDLE, LOAD_CUR, ACC_REF, DONE} state_t;

  state_t              state, state_nxt;
  logic [1:0]          cur_cnt;
  logic [2:0]          ref_cnt;
  logic [DATA_W-1:0]   cur   [4][4];
  logic [SUM_W-1:0]    acc   [16];
  logic [SUM_W-1:0]    acc_nxt [16];
  logic [SUM_W-1:0]    sum_q [16];
  logic                in_search;
  logic                accept;

  function automatic logic [DATA_W:0] abs_diff(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[DATA_W] ? $unsigned(-d) : $unsigned(d);
  endfunction

  assign in_search     = (state == LOAD_CUR) || (state == ACC_REF);
  assign accept        = bus.row_valid && in_search;
  assign bus.row_ready = in_search;
  assign bus.busy      = in_search;
  assign bus.done      = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.start) state_nxt = LOAD_CUR;
      LOAD_CUR: if (accept && cur_cnt == 2'd3) state_nxt = ACC_REF;
      ACC_REF:  if (accept && ref_cnt == 3'd6) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Reference row k contributes to row offset dy only when current row k-dy exists.
  always_comb begin
    int r;
    logic [SUM_W-1:0] sad;
    r   = 0;
    sad = '0;
    for (int i = 0; i < 16; i++) acc_nxt[i] = acc[i];
    for (int dy = 0; dy < 4; dy++) begin
      r = int'(ref_cnt) - dy;
      if (r >= 0 && r <= 3) begin
        for (int dx = 0; dx < 4; dx++) begin
          sad = '0;
          for (int c = 0; c < 4; c++)
            sad = sad + SUM_W'(abs_diff(cur[r[1:0]][c], bus.ref_row[8*(c+dx) +: 8]));
          acc_nxt[4*dy+dx] = acc[4*dy+dx] + sad;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_cnt <= '0;
      ref_cnt <= '0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) cur[r][c] <= '0;
      for (int i = 0; i < 16; i++) begin
        acc[i]   <= '0;
        sum_q[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (state == LOAD_CUR && accept) begin
        for (int c = 0; c < 4; c++) cur[cur_cnt][c] <= bus.cur_row[8*c +: 8];
        cur_cnt <= cur_cnt + 2'd1;
        ref_cnt <= '0;
        if (cur_cnt == 2'd3)
          for (int i = 0; i < 16; i++) acc[i] <= '0;
      end
      if (state == ACC_REF && accept) begin
        for (int i = 0; i < 16; i++) acc[i] <= acc_nxt[i];
        if (ref_cnt == 3'd6) begin
          ref_cnt <= '0;
          for (int i = 0; i < 16; i++) sum_q[i] <= acc_nxt[i];
        end else begin
          ref_cnt <= ref_cnt + 3'd1;
        end
      end
    end
  end

  assign bus.sum0  = sum_q[0];
  assign bus.sum1  = sum_q[1];
  assign bus.sum2  = sum_q[2];
  assign bus.sum3  = sum_q[3];
  assign bus.sum4  = sum_q[4];
  assign bus.sum5  = sum_q[5];
  assign bus.sum6  = sum_q[6];
  assign bus.sum7  = sum_q[7];
  assign bus.sum8  = sum_q[8];
  assign bus.sum9  = sum_q[9];
  assign bus.sum10 = sum_q[10];
  assign bus.sum11 = sum_q[11];
  assign bus.sum12 = sum_q[12];
  assign bus.sum13 = sum_q[13];
  assign bus.sum14 = sum_q[14];
  assign bus.sum15 = sum_q[15];
endmodule

// File: tb/tb_sad_array.sv
// Bench for sad_array: table-driven uniform searches, offset match, stalls, disturbances, random data.
module tb_sad_array;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sad_array_if ifc();
  sad_array dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  typedef struct { int cur_v; int ref_v; int exp_sum; } vec_t;

  int total = 0;
  int bad   = 0;
  int tc_cur [4][4];
  int tc_ref [7][7];
  int exp_s  [16];
  int prev_s [16];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int get_sum(input int i);
    case (i)
      0: return int'(ifc.sum0);   1: return int'(ifc.sum1);
      2: return int'(ifc.sum2);   3: return int'(ifc.sum3);
      4: return int'(ifc.sum4);   5: return int'(ifc.sum5);
      6: return int'(ifc.sum6);   7: return int'(ifc.sum7);
      8: return int'(ifc.sum8);   9: return int'(ifc.sum9);
      10: return int'(ifc.sum10); 11: return int'(ifc.sum11);
      12: return int'(ifc.sum12); 13: return int'(ifc.sum13);
      14: return int'(ifc.sum14); 15: return int'(ifc.sum15);
      default: return 0;
    endcase
  endfunction

  // Direct SAD definition: candidate (dy,dx) compares cur[r][c] with window[r+dy][c+dx].
  function automatic void model();
    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++) begin
        int s = 0;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            int d = tc_cur[r][c] - tc_ref[r+dy][c+dx];
            s += (d < 0) ? -d : d;
          end
        exp_s[4*dy+dx] = s;
      end
  endfunction

  task automatic check_sums(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s sum%0d", tag, i), get_sum(i), exp_s[i]);
  endtask

  task automatic fill_uniform(input int cv, input int rv);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) tc_cur[r][c] = cv;
    for (int y = 0; y < 7; y++) for (int x = 0; x < 7; x++) tc_ref[y][x] = rv;
  endtask

  task automatic fill_random();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) tc_cur[r][c] = int'($urandom_range(255));
    for (int y = 0; y < 7; y++) for (int x = 0; x < 7; x++) tc_ref[y][x] = int'($urandom_range(255));
  endtask

  task automatic drive_row(input int idx);
    ifc.cur_row = $urandom;
    ifc.ref_row = 56'({$urandom, $urandom});
    if (idx < 4) begin
      for (int c = 0; c < 4; c++) ifc.cur_row[8*c +: 8] = 8'(tc_cur[idx][c]);
    end else if (idx < 11) begin
      for (int x = 0; x < 7; x++) ifc.ref_row[8*x +: 8] = 8'(tc_ref[idx-4][x]);
    end
  endtask

  // lat counts cycles after the start-sampling edge until done is seen.
  task automatic search(input int stall_mode, input int inj_start_k, input bit rst_mid,
                        output int lat, output int stalls, output bit got_done);
    int idx;
    bit v;
    lat = 0; stalls = 0; got_done = 0; idx = 0;
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.row_valid = 1'b0;
    @(negedge clk);
    ifc.start = 1'b0;
    for (int k = 1; k < 200; k++) begin
      if (k > 1) @(negedge clk);
      if (ifc.done) begin
        got_done = 1'b1;
        lat = k;
        break;
      end
      if (k == 6) begin
        int diffs = 0;
        for (int i = 0; i < 16; i++) if (get_sum(i) != prev_s[i]) diffs++;
        check("sums held during search", diffs, 0);
      end
      ifc.start = (k == inj_start_k);
      if (stall_mode == 0)      v = 1'b1;
      else if (stall_mode == 1) v = (k % 2 == 0);
      else                      v = ($urandom_range(3) != 0);
      ifc.row_valid = v;
      drive_row(idx);
      if (ifc.busy && !v) stalls++;
      if (rst_mid && idx == 6 && v && ifc.row_ready) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ifc.row_valid = 1'b0;
        ifc.start = 1'b0;
        return;
      end
      if (v && ifc.row_ready) idx++;
    end
    ifc.row_valid = 1'b0;
    ifc.start = 1'b0;
    check("search completes", int'(got_done), 1);
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    check({tag, " done one cycle"}, int'(ifc.done), 0);
    check({tag, " idle after done"}, int'(ifc.busy), 0);
    for (int i = 0; i < 16; i++) prev_s[i] = exp_s[i];
  endtask

  initial begin
    vec_t vecs [5];
    int lat, stalls, best, mv, done_seen, busy_seen;
    bit got;

    vecs[0] = '{10, 10, 0};
    vecs[1] = '{0, 255, 4080};
    vecs[2] = '{255, 0, 4080};
    vecs[3] = '{100, 50, 800};
    vecs[4] = '{3, 7, 64};

    ifc.start = 1'b0; ifc.row_valid = 1'b0; ifc.cur_row = '0; ifc.ref_row = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin exp_s[i] = 0; prev_s[i] = 0; end
    check_sums("reset");
    check("reset busy", int'(ifc.busy), 0);
    check("reset done", int'(ifc.done), 0);
    check("reset row_ready", int'(ifc.row_ready), 0);
    rst_n = 1'b1;

    ifc.row_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      drive_row(0);
      check("idle row_valid ignored", int'(ifc.row_ready | ifc.busy), 0);
    end
    ifc.row_valid = 1'b0;

    for (int v = 0; v < 5; v++) begin
      fill_uniform(vecs[v].cur_v, vecs[v].ref_v);
      for (int i = 0; i < 16; i++) exp_s[i] = vecs[v].exp_sum;
      search(0, 0, 1'b0, lat, stalls, got);
      check($sformatf("vec%0d latency", v), lat, 12);
      check_sums($sformatf("vec%0d", v));
      after_done($sformatf("vec%0d", v));
    end

    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) tc_cur[r][c] = 16*r + c + 1;
    for (int y = 0; y < 7; y++)
      for (int x = 0; x < 7; x++)
        tc_ref[y][x] = (y >= 2 && y <= 5 && x >= 1 && x <= 4) ? tc_cur[y-2][x-1] : 200;
    model();
    search(0, 0, 1'b0, lat, stalls, got);
    check_sums("offset");
    check("offset sum9", get_sum(9), 0);
    best = 0;
    for (int i = 1; i < 16; i++) if (get_sum(i) < get_sum(best)) best = i;
    mv = ((best >> 2) << 4) | (best & 3);
    check("offset mv", mv, 'h21);
    after_done("offset");

    fill_uniform(10, 10);
    model();
    search(1, 0, 1'b0, lat, stalls, got);
    check("stall stalled cycles", stalls, 11);
    check("stall latency", lat, 12 + stalls);
    check_sums("stall");
    after_done("stall");

    fill_random();
    model();
    search(0, 7, 1'b0, lat, stalls, got);
    check("restart ignored latency", lat, 12);
    check_sums("restart ignored");
    after_done("restart ignored");
    repeat (3) @(negedge clk);
    check("no queued search", int'(ifc.busy), 0);

    fill_random();
    search(0, 0, 1'b1, lat, stalls, got);
    done_seen = 0; busy_seen = 0;
    ifc.row_valid = 1'b1;
    repeat (15) begin
      if (ifc.done) done_seen++;
      if (ifc.busy) busy_seen++;
      @(negedge clk);
    end
    ifc.row_valid = 1'b0;
    check("mid reset no done", done_seen, 0);
    check("mid reset idle", busy_seen, 0);
    for (int i = 0; i < 16; i++) begin exp_s[i] = 0; prev_s[i] = 0; end
    check_sums("mid reset");

    for (int t = 0; t < 6; t++) begin
      fill_random();
      model();
      search(2, 0, 1'b0, lat, stalls, got);
      check($sformatf("rand%0d latency", t), lat, 12 + stalls);
      check_sums($sformatf("rand%0d", t));
      after_done($sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
